// File: rtl/conv3x3_stream_engine_if.sv
// Pixel-in / result-out stream bundle for the 3x3 convolution engine.
// The slave modport is the engine's view; the master modport is the
// upstream source / downstream sink view.
interface conv3x3_stream_engine_if #(
  parameter int PX_W  = 8,
  parameter int OUT_W = 16
);
  logic              in_valid_i;
  logic              in_ready_o;
  logic [PX_W-1:0]   in_px_i;
  logic              out_valid_o;
  logic              out_ready_i;
  logic [OUT_W-1:0]  out_data_o;
  logic              out_last_o;

  modport slave (
    input  in_valid_i, in_px_i, out_ready_i,
    output in_ready_o, out_valid_o, out_data_o, out_last_o
  );

  modport master (
    output in_valid_i, in_px_i, out_ready_i,
    input  in_ready_o, out_valid_o, out_data_o, out_last_o
  );
endinterface

// File: rtl/conv3x3_stream_engine.sv
// Streaming 3x3 "valid"-mode convolution over an IMG_W x IMG_H raster frame.
// Each pixel arrives once; two line buffers supply the two rows above it and
// a 3x3 register window slides left on every accepted pixel. Results are
// scaled by an arithmetic right shift, saturated and registered (latency 1).
module conv3x3_stream_engine #(
  parameter int IMG_W      = 32,
  parameter int IMG_H      = 32,
  parameter int PX_W       = 8,
  parameter int COEF_W     = 8,
  parameter int OUT_W      = 16,
  parameter int FRAC_SHIFT = 6
) (
  input  logic                  clk_i,
  input  logic                  nreset_i,
  input  logic [9*COEF_W-1:0]   kernel_i,
  input  logic                  start_i,
  input  logic                  clear_i,
  output logic                  busy_o,
  output logic                  frame_done_o,
  conv3x3_stream_engine_if.slave s_if
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam int AW = PX_W + COEF_W + 5;
  localparam logic [CW-1:0] LAST_COL = CW'(IMG_W - 1);
  localparam logic [RW-1:0] LAST_ROW = RW'(IMG_H - 1);
  localparam logic signed [AW-1:0] SAT_MAX = AW'((64'sd1 <<< (OUT_W - 1)) - 64'sd1);
  localparam logic signed [AW-1:0] SAT_MIN = AW'(-(64'sd1 <<< (OUT_W - 1)));

  typedef enum logic [1:0] {S_IDLE, S_STREAM, S_DRAIN} state_t;

  state_t              r_state;
  state_t              w_next;
  logic [CW-1:0]       r_col;
  logic [RW-1:0]       r_row;
  logic [PX_W-1:0]     r_lb0 [IMG_W];
  logic [PX_W-1:0]     r_lb1 [IMG_W];
  logic [PX_W-1:0]     r_win [3][3];
  logic [PX_W-1:0]     w_win [3][3];
  logic                r_out_valid;
  logic                r_out_last;
  logic [OUT_W-1:0]    r_out_data;
  logic                w_in_ready;
  logic                w_accept;
  logic                w_win_valid;
  logic                w_last_px;
  logic signed [AW-1:0] w_acc;
  logic signed [AW-1:0] w_shift;
  logic [OUT_W-1:0]    w_sat;

  assign w_in_ready  = (r_state == S_STREAM) && (!r_out_valid || s_if.out_ready_i);
  assign w_accept    = s_if.in_valid_i && w_in_ready;
  assign w_win_valid = (r_row >= RW'(2)) && (r_col >= CW'(2));
  assign w_last_px   = (r_row == LAST_ROW) && (r_col == LAST_COL);

  assign s_if.in_ready_o  = w_in_ready;
  assign s_if.out_valid_o = r_out_valid;
  assign s_if.out_data_o  = r_out_data;
  assign s_if.out_last_o  = r_out_last;
  assign busy_o           = (r_state != S_IDLE);

  // State register.
  always_ff @(posedge clk_i or negedge nreset_i) begin
    if (!nreset_i) r_state <= S_IDLE;
    else           r_state <= w_next;
  end

  // Next-state logic; abort wins over everything and suppresses frame_done.
  always_comb begin
    w_next       = r_state;
    frame_done_o = 1'b0;
    if (clear_i) begin
      w_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:   if (start_i) w_next = S_STREAM;
        S_STREAM: if (w_accept && w_last_px) w_next = S_DRAIN;
        S_DRAIN: begin
          if (!r_out_valid || s_if.out_ready_i) begin
            w_next       = S_IDLE;
            frame_done_o = 1'b1;
          end
        end
        default:  w_next = S_IDLE;
      endcase
    end
  end

  // Raster position of the next pixel to be accepted.
  always_ff @(posedge clk_i or negedge nreset_i) begin
    if (!nreset_i) begin
      r_col <= '0;
      r_row <= '0;
    end else if (clear_i || (r_state == S_IDLE && start_i)) begin
      r_col <= '0;
      r_row <= '0;
    end else if (w_accept) begin
      if (r_col == LAST_COL) begin
        r_col <= '0;
        r_row <= r_row + RW'(1);
      end else begin
        r_col <= r_col + CW'(1);
      end
    end
  end

  // Line buffers age one row per visit to a column; no reset needed since
  // windows only use entries written earlier in the same frame.
  always_ff @(posedge clk_i) begin
    if (w_accept && !clear_i) begin
      r_lb0[r_col] <= r_lb1[r_col];
      r_lb1[r_col] <= s_if.in_px_i;
    end
  end

  // Shifted window: rows move left, new right column is {row r-2, r-1, r}.
  always_comb begin
    for (int r = 0; r < 3; r++) begin
      w_win[r][0] = r_win[r][1];
      w_win[r][1] = r_win[r][2];
    end
    w_win[0][2] = r_lb0[r_col];
    w_win[1][2] = r_lb1[r_col];
    w_win[2][2] = s_if.in_px_i;
  end

  // Window register updates on every accepted pixel.
  always_ff @(posedge clk_i or negedge nreset_i) begin
    if (!nreset_i)     r_win <= '{default: '0};
    else if (w_accept) r_win <= w_win;
  end

  // Multiply-accumulate over the shifted window, floor-shift, then saturate.
  always_comb begin
    w_acc = '0;
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 3; c++) begin
        w_acc = w_acc
              + ($signed({{(AW-PX_W){1'b0}}, w_win[r][c]})
              *  $signed({{(AW-COEF_W){kernel_i[(3*r+c)*COEF_W + COEF_W-1]}},
                          kernel_i[(3*r+c)*COEF_W +: COEF_W]}));
      end
    end
    w_shift = w_acc >>> FRAC_SHIFT;
    if (w_shift > SAT_MAX)      w_sat = SAT_MAX[OUT_W-1:0];
    else if (w_shift < SAT_MIN) w_sat = SAT_MIN[OUT_W-1:0];
    else                        w_sat = w_shift[OUT_W-1:0];
  end

  // Output register with AXI-stream hold semantics; abort discards any result.
  always_ff @(posedge clk_i or negedge nreset_i) begin
    if (!nreset_i) begin
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_out_data  <= '0;
    end else if (clear_i) begin
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_out_data  <= '0;
    end else if (w_accept && w_win_valid) begin
      r_out_valid <= 1'b1;
      r_out_last  <= w_last_px;
      r_out_data  <= w_sat;
    end else if (s_if.out_ready_i) begin
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
    end
  end

endmodule
